// File: rtl/storage_pkg.sv
// Shared types and default constants for the storage command sequencer.
package storage_pkg;

    // Sequencer states: waiting for keys, running auto-shift, one-cycle completion
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AUTO = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Default auto-shift timing: one step per 12.5M cycles, eight steps per byte
    localparam int DEF_STEP_DIV = 12_500_000;
    localparam int DEF_NSTEPS   = 8;
    localparam int DEF_DIV_W    = 24;

endpackage : storage_pkg

// File: rtl/step_prescaler.sv
// Loadable down-counter with a zero flag; paces the auto-shift steps and
// is generic enough to pace display blinking as well.
module step_prescaler #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Load takes precedence over decrement; the count holds when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {W{1'b0}};
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i) begin
            cnt_q <= cnt_q - W'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign zero_o = (cnt_q == {W{1'b0}});

endmodule : step_prescaler

// File: rtl/storage_seq_ctrl.sv
// Command sequencer/arbiter for the record/shift/copy storage datapath.
// Key pulses are arbitrated by fixed priority into one registered strobe per
// cycle; an auto mode issues NSTEPS transfer strobes STEP_DIV cycles apart.
module storage_seq_ctrl
    import storage_pkg::*;
#(
    parameter int STEP_DIV = DEF_STEP_DIV,
    parameter int NSTEPS   = DEF_NSTEPS,
    parameter int DIV_W    = DEF_DIV_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          record_req,
    input  logic                          transfer_req,
    input  logic                          copy_req,
    input  logic                          auto_req,
    input  logic                          abort_req,
    output logic                          record_o,
    output logic                          transfer_o,
    output logic                          copy_o,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(NSTEPS+1)-1:0]   step_cnt
);

    localparam int CNT_W = $clog2(NSTEPS + 1);

    seq_state_e       state_q;
    logic [CNT_W-1:0] step_cnt_q;
    logic             record_q;
    logic             transfer_q;
    logic             copy_q;
    logic             done_q;

    logic             pre_load;
    logic             pre_en;
    logic             pre_zero;
    logic             auto_win;
    logic             last_step;

    // auto_req only wins when no datapath command is requested alongside it
    assign auto_win  = auto_req & ~record_req & ~copy_req & ~transfer_req;
    assign last_step = (step_cnt_q == CNT_W'(NSTEPS - 1));

    // Prescaler control: load on auto start and after each non-final step,
    // count down otherwise while AUTO runs; abort freezes it
    always_comb begin
        pre_load = 1'b0;
        pre_en   = 1'b0;
        case (state_q)
            IDLE: begin
                pre_load = auto_win;
            end
            AUTO: begin
                if (abort_req) begin
                    pre_en = 1'b0;
                end else if (pre_zero) begin
                    pre_load = ~last_step;
                end else begin
                    pre_en = 1'b1;
                end
            end
            default: begin
                pre_load = 1'b0;
                pre_en   = 1'b0;
            end
        endcase
    end

    step_prescaler #(
        .W (DIV_W)
    ) u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .load_i     (pre_load),
        .load_val_i (DIV_W'(STEP_DIV - 1)),
        .en_i       (pre_en),
        .zero_o     (pre_zero)
    );

    // Sequencer FSM with registered strobes; strobes default low every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            step_cnt_q <= {CNT_W{1'b0}};
            record_q   <= 1'b0;
            transfer_q <= 1'b0;
            copy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            record_q   <= 1'b0;
            transfer_q <= 1'b0;
            copy_q     <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (record_req) begin
                        record_q <= 1'b1;
                    end else if (copy_req) begin
                        copy_q <= 1'b1;
                    end else if (transfer_req) begin
                        transfer_q <= 1'b1;
                    end else if (auto_req) begin
                        state_q    <= AUTO;
                        step_cnt_q <= {CNT_W{1'b0}};
                    end else begin
                        state_q <= IDLE;
                    end
                end
                AUTO: begin
                    if (abort_req) begin
                        state_q <= IDLE;
                    end else if (pre_zero) begin
                        transfer_q <= 1'b1;
                        step_cnt_q <= step_cnt_q + CNT_W'(1);
                        if (last_step) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= AUTO;
                        end
                    end else begin
                        state_q <= AUTO;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign record_o   = record_q;
    assign transfer_o = transfer_q;
    assign copy_o     = copy_q;
    assign done       = done_q;
    assign step_cnt   = step_cnt_q;
    assign busy       = (state_q != IDLE);

endmodule : storage_seq_ctrl

// File: tb/tb_storage_seq_ctrl.sv
// Scoreboard bench for storage_seq_ctrl: each stimulus pushes its expected
// strobes (cycle + which output) into a queue; a monitor pops on every strobe.
module tb_storage_seq_ctrl;
    import storage_pkg::*;

    localparam int SD = 4;
    localparam int NS = DEF_NSTEPS;
    localparam int CW = $clog2(NS + 1);

    localparam logic [3:0] EV_REC = 4'b0001;
    localparam logic [3:0] EV_TRF = 4'b0010;
    localparam logic [3:0] EV_CPY = 4'b0100;
    localparam logic [3:0] EV_DON = 4'b1000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          record_req = 1'b0;
    logic          transfer_req = 1'b0;
    logic          copy_req = 1'b0;
    logic          auto_req = 1'b0;
    logic          abort_req = 1'b0;
    logic          record_o, transfer_o, copy_o, busy, done;
    logic [CW-1:0] step_cnt;

    storage_seq_ctrl #(
        .STEP_DIV (SD),
        .NSTEPS   (NS),
        .DIV_W    (DEF_DIV_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .record_req   (record_req),
        .transfer_req (transfer_req),
        .copy_req     (copy_req),
        .auto_req     (auto_req),
        .abort_req    (abort_req),
        .record_o     (record_o),
        .transfer_o   (transfer_o),
        .copy_o       (copy_o),
        .busy         (busy),
        .done         (done),
        .step_cnt     (step_cnt)
    );

    always #5 clk = ~clk;

    // cycle n is the interval following the n-th rising edge
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] ev;
    } exp_t;
    exp_t sb_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: cycle %0d got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic expect_ev(int c, logic [3:0] ev);
        exp_t e;
        e.cyc = c;
        e.ev  = ev;
        sb_q.push_back(e);
    endtask

    task automatic wait_to(int c);
        while (cyc < c) @(negedge clk);
    endtask

    // r = {abort, auto, transfer, copy, record}, held for exactly cycle c
    task automatic issue(int c, logic [4:0] r);
        wait_to(c);
        {abort_req, auto_req, transfer_req, copy_req, record_req} = r;
        @(negedge clk);
        {abort_req, auto_req, transfer_req, copy_req, record_req} = 5'b00000;
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_record_o"},   int'(record_o),   0);
        chk({tag, "_transfer_o"}, int'(transfer_o), 0);
        chk({tag, "_copy_o"},     int'(copy_o),     0);
        chk({tag, "_done"},       int'(done),       0);
        chk({tag, "_busy"},       int'(busy),       0);
        chk({tag, "_step_cnt"},   int'(step_cnt),   0);
    endtask

    // Monitor: every observed strobe must match the head of the scoreboard
    always @(negedge clk) begin
        logic [3:0] seen;
        exp_t       e;
        seen = {done, copy_o, transfer_o, record_o};
        if (!rst && seen != 4'b0000) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe: cycle %0d got %b expected none", cyc, seen);
            end else begin
                e = sb_q.pop_front();
                if (e.cyc != cyc || e.ev != seen) begin
                    n_fail++;
                    $display("FAIL strobe: got %b in cycle %0d expected %b in cycle %0d",
                             seen, cyc, e.ev, e.cyc);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;

        // Reset state
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single requests: strobe one cycle after the request cycle only
        base = cyc + 1;
        expect_ev(base + 3,  EV_REC);
        expect_ev(base + 7,  EV_CPY);
        expect_ev(base + 11, EV_TRF);
        issue(base + 2,  5'b00001);
        issue(base + 6,  5'b00010);
        issue(base + 10, 5'b00100);
        wait_to(base + 14);
        chk("single_busy", int'(busy), 0);

        // Simultaneous record/copy/transfer/auto: only record wins
        base = cyc + 1;
        expect_ev(base + 6, EV_REC);
        issue(base + 5, 5'b01111);
        chk("simul_busy_c6", int'(busy), 0);
        wait_to(base + 12);
        chk("simul_busy_c12", int'(busy), 0);

        // Full auto run with ignored requests at cycle 7
        base = cyc + 1;
        for (int i = 0; i < NS; i++) expect_ev(base + 5 + SD * i, EV_TRF);
        expect_ev(base + 34, EV_DON);
        issue(base, 5'b01000);
        chk("auto_busy_c1", int'(busy), 1);
        chk("auto_step_c1", int'(step_cnt), 0);
        issue(base + 7, 5'b01011);
        wait_to(base + 33);
        chk("auto_busy_c33", int'(busy), 1);
        wait_to(base + 34);
        chk("auto_busy_c34", int'(busy), 0);
        chk("auto_step_c34", int'(step_cnt), 8);
        wait_to(base + 38);
        chk("auto_step_hold", int'(step_cnt), 8);

        // Abort coinciding with the third step
        base = cyc + 1;
        expect_ev(base + 5, EV_TRF);
        expect_ev(base + 9, EV_TRF);
        issue(base, 5'b01000);
        wait_to(base + 12);
        chk("abort_busy_c12", int'(busy), 1);
        issue(base + 12, 5'b10000);
        chk("abort_busy_c13", int'(busy), 0);
        wait_to(base + 14);
        chk("abort_step_c14", int'(step_cnt), 2);
        issue(base + 16, 5'b10000);
        wait_to(base + 40);
        chk("abort_idle_busy", int'(busy), 0);
        chk("abort_step_hold", int'(step_cnt), 2);

        // Asynchronous reset in the middle of AUTO
        base = cyc + 1;
        expect_ev(base + 5, EV_TRF);
        expect_ev(base + 9, EV_TRF);
        issue(base, 5'b01000);
        wait_to(base + 10);
        chk("midrst_busy_pre", int'(busy), 1);
        chk("midrst_step_pre", int'(step_cnt), 2);
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        wait_to(base + 24);
        chk("midrst_busy_post", int'(busy), 0);

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_storage_seq_ctrl

// File: doc/storage_seq_ctrl.md
Name: storage_seq_ctrl

Overview:
- Command sequencer/arbiter in front of the 8-bit record/shift/copy storage datapath.
- Inputs: debounced single-cycle key pulses (record, transfer, copy, auto, abort).
- Arbitrates simultaneous requests and issues one mutually exclusive, registered command strobe per cycle to the datapath.
- Adds an auto-shift mode: emits NSTEPS transfer strobes spaced STEP_DIV cycles apart, so a whole byte shifts red→green without repeated key presses.

Parameters:
- STEP_DIV, 12_500_000: clock cycles between auto-mode transfer strobes; legal range ≥2.
- NSTEPS, 8: number of transfer strobes per auto sequence; legal range ≥1.
- DIV_W, 24: prescaler counter width; must satisfy 2^DIV_W > STEP_DIV-1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- record_req  in  1  single-cycle request: load switches into red register.
- transfer_req  in  1  single-cycle request: one manual shift step.
- copy_req  in  1  single-cycle request: copy red into green.
- auto_req  in  1  single-cycle request: start auto-shift sequence.
- abort_req  in  1  single-cycle request: cancel auto sequence.
- record_o  out  1  registered command strobe to datapath.
- transfer_o  out  1  registered command strobe to datapath.
- copy_o  out  1  registered command strobe to datapath.
- busy  out  1  high while auto sequence is in progress.
- done  out  1  one-cycle pulse after an auto sequence completes normally.
- step_cnt  out  $clog2(NSTEPS+1)  transfers issued in the current/last auto sequence.

Behaviour:
- Reset (async, any state): state=IDLE; prescaler=0; step_cnt=0; record_o, transfer_o, copy_o, done all 0.
- All strobes are registered: a request sampled at edge k produces its strobe high during cycle k+1 for exactly one cycle.
- At most one of record_o/transfer_o/copy_o is high in any cycle.
- States: IDLE, AUTO, DONE. busy = (state != IDLE), decoded from the state register.
- IDLE, fixed priority record_req > copy_req > transfer_req > auto_req:
  - The winner is served; all lower requests in the same cycle are dropped, not queued.
  - auto_req as winner → AUTO, prescaler=STEP_DIV-1, step_cnt=0, no strobe that edge.
  - abort_req in IDLE has no effect.
- AUTO:
  - record/copy/transfer/auto requests are ignored (dropped).
  - Prescaler decrements each cycle.
  - At the edge where prescaler==0: transfer_o<=1 and step_cnt<=step_cnt+1.
    - If step_cnt==NSTEPS-1: go to DONE.
    - Otherwise: prescaler reloads to STEP_DIV-1.
  - The first strobe appears STEP_DIV cycles after AUTO entry; later strobes are exactly STEP_DIV cycles apart.
  - abort_req wins over a coincident prescaler==0: → IDLE, no strobe, step_cnt holds its partial value, done stays 0.
- DONE: done<=1 (visible in the following cycle, concurrent with IDLE); state → IDLE; requests in DONE are ignored.
- step_cnt holds after DONE or abort until the next auto start or reset.
- Prescaler width: DIV_W bits, unsigned; no wrap under legal parameters.

Decomposition:
- Shared package storage_pkg: state enum (IDLE, AUTO, DONE); default STEP_DIV/NSTEPS constants, shared with the top level and bench.
- One sub-module: step_prescaler.
  - Loadable down-counter with load/enable inputs and a zero flag.
  - Instantiated once; reusable for the display blink logic.

Test Plan:
- Reset mid-AUTO (STEP_DIV=4, NSTEPS=8, rst at cycle 10) → all outputs 0 immediately; busy=0 and step_cnt=0 without waiting for a clock edge.
- Single requests: record_req@cycle 2 → record_o high only in cycle 3. Same check for copy_req and transfer_req; no other strobe fires.
- Simultaneous requests: record_req+copy_req+transfer_req+auto_req all in cycle 5 → only record_o in cycle 6; state stays IDLE.
- Full auto run (STEP_DIV=4, NSTEPS=8, auto_req@0):
  - transfer_o high in cycles 5, 9, 13, …, 33 (8 pulses).
  - busy high in cycles 1–33; done high in cycle 34 only; step_cnt=8.
- Requests during AUTO: record_req/copy_req/auto_req in cycle 7 → no record_o/copy_o; the transfer_o schedule is unchanged.
- Abort: auto_req@0, abort_req@12 (coincides with the prescaler==0 that would yield the strobe in cycle 13) → no transfer_o in cycle 13; busy=0 from cycle 13; step_cnt=2; done never asserted.
